// File: rtl/regfile_access_arbiter.sv
// rtl/regfile_access_arbiter.sv - init sweep plus round-robin owner of the register file port
module regfile_access_arbiter #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         r0_valid,
  input  logic         r0_we,
  input  logic [D-1:0] r0_addr,
  input  logic [W-1:0] r0_wdata,
  output logic         r0_ready,
  output logic         r0_rvalid,
  output logic [W-1:0] r0_rdata,
  input  logic         r1_valid,
  input  logic         r1_we,
  input  logic [D-1:0] r1_addr,
  input  logic [W-1:0] r1_wdata,
  output logic         r1_ready,
  output logic         r1_rvalid,
  output logic [W-1:0] r1_rdata,
  output logic         rf_write_en,
  output logic [D-1:0] rf_addr,
  output logic [W-1:0] rf_data_in,
  input  logic [W-1:0] rf_data_out,
  output logic         init_done
);

  typedef enum logic {S_INIT = 1'b0, S_ARB = 1'b1} state_t;

  state_t       state;
  state_t       state_next;
  logic [D-1:0] init_cnt;
  logic         last_grant;
  logic         gnt0;
  logic         gnt1;
  logic         init_last;

  assign init_last = (init_cnt == {D{1'b1}});
  assign init_done = (state == S_ARB);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave the sweep after the last register address is written
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (init_last) state_next = S_ARB;
      S_ARB:   state_next = S_ARB;
      default: state_next = S_INIT;
    endcase
  end

  // Round-robin grant: on a tie the port that did not win last time gets the port
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && state == S_ARB) begin
      if (r0_valid && r1_valid) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = r0_valid;
        gnt1 = r1_valid;
      end
    end
  end

  // Outputs: sweep writes zeros, otherwise the granted port drives the register file
  always_comb begin
    rf_write_en = 1'b0;
    rf_addr     = '0;
    rf_data_in  = '0;
    r0_ready    = gnt0;
    r1_ready    = gnt1;
    if (!reset) begin
      if (state == S_INIT) begin
        rf_write_en = 1'b1;
        rf_addr     = init_cnt;
      end else if (gnt0) begin
        rf_write_en = r0_we;
        rf_addr     = r0_addr;
        rf_data_in  = r0_we ? r0_wdata : '0;
      end else if (gnt1) begin
        rf_write_en = r1_we;
        rf_addr     = r1_addr;
        rf_data_in  = r1_we ? r1_wdata : '0;
      end
    end
  end

  // Sweep counter, grant history and registered read responses
  always_ff @(posedge clk) begin
    if (reset) begin
      init_cnt   <= '0;
      last_grant <= 1'b1;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      if (state == S_INIT) begin
        init_cnt <= init_cnt + {{(D-1){1'b0}}, 1'b1};
      end
      if (gnt0) begin
        last_grant <= 1'b0;
      end else if (gnt1) begin
        last_grant <= 1'b1;
      end
      r0_rvalid <= gnt0 && !r0_we;
      r1_rvalid <= gnt1 && !r1_we;
      if (gnt0 && !r0_we) r0_rdata <= rf_data_out;
      if (gnt1 && !r1_we) r1_rdata <= rf_data_out;
    end
  end

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb/tb_regfile_access_arbiter.sv - scoreboard bench for regfile_access_arbiter
module tb_regfile_access_arbiter;
  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         r0_valid, r0_we, r0_ready, r0_rvalid;
  logic [D-1:0] r0_addr;
  logic [W-1:0] r0_wdata, r0_rdata;
  logic         r1_valid, r1_we, r1_ready, r1_rvalid;
  logic [D-1:0] r1_addr;
  logic [W-1:0] r1_wdata, r1_rdata;
  logic         rf_write_en;
  logic [D-1:0] rf_addr;
  logic [W-1:0] rf_data_in, rf_data_out;
  logic         init_done;

  regfile_access_arbiter #(.W(W), .D(D)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ready(r0_ready), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ready(r1_ready), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .rf_write_en(rf_write_en), .rf_addr(rf_addr), .rf_data_in(rf_data_in),
    .rf_data_out(rf_data_out), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Environment register file (no reset); scramble loads nonzero junk
  logic         scramble;
  logic [W-1:0] rf_mem [N];
  assign rf_data_out = rf_mem[rf_addr];
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < N; i++) rf_mem[i] <= W'($urandom_range(1, 255));
    end else if (rf_write_en) begin
      rf_mem[rf_addr] <= rf_data_in;
    end
  end

  typedef struct { int due; logic [W-1:0] data; } rsp_t;
  rsp_t         q0[$];
  rsp_t         q1[$];
  logic [W-1:0] model_mem [N];
  int           sweep_pos = 0;
  int           last_port = 1;
  bit           model_on = 0;
  int           cyc = 0;
  int           last_reset_cyc = -1;
  int           pg = -1;
  bit           pg_we;
  logic [D-1:0] pg_addr;
  logic [W-1:0] pg_data;
  logic [W-1:0] held0, held1;
  int           pass_cnt = 0;
  int           total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
  endtask

  // Reference: expected combinational outputs from the arbitration rules
  always @(negedge clk) begin
    int g;
    bit e_we;
    int e_addr, e_din;
    if (model_on) begin
      g = -1; e_we = 0; e_addr = 0; e_din = 0;
      if (!reset) begin
        if (sweep_pos < N) begin
          e_we = 1; e_addr = sweep_pos;
        end else begin
          if (r0_valid && r1_valid) g = 1 - last_port;
          else if (r0_valid) g = 0;
          else if (r1_valid) g = 1;
          if (g == 0) begin e_we = r0_we; e_addr = int'(r0_addr); e_din = r0_we ? int'(r0_wdata) : 0; end
          if (g == 1) begin e_we = r1_we; e_addr = int'(r1_addr); e_din = r1_we ? int'(r1_wdata) : 0; end
        end
      end
      check("rf_write_en", rf_write_en, e_we);
      check("rf_addr", rf_addr, e_addr);
      check("rf_data_in", rf_data_in, e_din);
      check("r0_ready", r0_ready, g == 0);
      check("r1_ready", r1_ready, g == 1);
      check("init_done", init_done, sweep_pos >= N);
      pg      = g;
      pg_we   = e_we;
      pg_addr = D'(e_addr);
      pg_data = W'(e_din);
    end
  end

  // Reference state advance at each edge; read grants push expected responses
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      model_on = 1; sweep_pos = 0; last_port = 1; last_reset_cyc = cyc;
    end else if (model_on) begin
      if (sweep_pos < N) begin
        sweep_pos++;
        if (sweep_pos == N) for (int i = 0; i < N; i++) model_mem[i] = '0;
      end else if (pg >= 0) begin
        last_port = pg;
        if (pg_we) model_mem[pg_addr] = pg_data;
        else if (pg == 0) q0.push_back('{due: cyc, data: model_mem[pg_addr]});
        else q1.push_back('{due: cyc, data: model_mem[pg_addr]});
      end
    end
  end

  // Monitor: pops the scoreboard when a response is due
  always @(negedge clk) begin
    if (model_on) begin
      if (last_reset_cyc == cyc) begin
        q0.delete(); q1.delete(); held0 = '0; held1 = '0;
      end
      if (q0.size() > 0 && q0[0].due == cyc) begin
        held0 = q0[0].data; void'(q0.pop_front()); check("r0_rvalid", r0_rvalid, 1);
      end else check("r0_rvalid", r0_rvalid, 0);
      check("r0_rdata", r0_rdata, held0);
      if (q1.size() > 0 && q1[0].due == cyc) begin
        held1 = q1[0].data; void'(q1.pop_front()); check("r1_rvalid", r1_rvalid, 1);
      end else check("r1_rvalid", r1_rvalid, 0);
      check("r1_rdata", r1_rdata, held1);
    end
  end

  task automatic drive(input bit v0, input bit w0, input int a0, input int d0,
                       input bit v1, input bit w1, input int a1, input int d1);
    r0_valid = v0; r0_we = w0; r0_addr = D'(a0); r0_wdata = W'(d0);
    r1_valid = v1; r1_we = w1; r1_addr = D'(a1); r1_wdata = W'(d1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; scramble = 1;
    r0_valid = 0; r0_we = 0; r0_addr = '0; r0_wdata = '0;
    r1_valid = 0; r1_we = 0; r1_addr = '0; r1_wdata = '0;
    repeat (3) @(posedge clk);
    #1; scramble = 0; reset = 0;
    idle(20);
    for (int i = 0; i < N; i++) drive(0, 0, 0, 0, 1, 0, i, 0);
    drive(1, 1, 3, 8'hA5, 0, 0, 0, 0);
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 8'h11, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 2, 8'h22);
    for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, 1, 0, 2, 0);
    idle(2);
    for (int i = 0; i < 5; i++) drive(i == 2, 0, 5, 0, 1, 0, 3, 0);
    idle(2);
    reset = 1; scramble = 1;
    drive(1, 0, 7, 0, 0, 0, 0, 0);
    scramble = 0; reset = 0;
    for (int i = 0; i < 18; i++) drive(1, 0, 7, 0, 0, 0, 0, 0);
    drive(1, 1, 3, 8'h5A, 0, 0, 0, 0);
    r0_valid = 1; r0_we = 0; r0_addr = 4'd3;
    @(negedge clk); #1;
    reset = 1; r0_valid = 0;
    @(posedge clk); #1;
    idle(1);
    reset = 0;
    idle(20);
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, N - 1), $urandom_range(0, 255),
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, N - 1), $urandom_range(0, 255));
    end
    reset = 0;
    idle(25);
    check("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
Owns the single address/data port of the 2^D x W register file and shares it between two requesters: port 0 (core datapath) and port 1 (loader/debug). After reset it runs an init sweep that writes zero to every register, because the register file itself has no reset. After the sweep it grants one access per cycle using round-robin arbitration. Read data returns registered one cycle after the grant.

Parameters:
W, 8, data width (matches register file width)
D, 4, address width; register count = 2^D

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
r0_valid  input  1  port 0 request valid
r0_we  input  1  port 0 op: 1 = write, 0 = read
r0_addr  input  D  port 0 register address
r0_wdata  input  W  port 0 write data
r0_ready  output  1  port 0 request accepted this cycle
r0_rvalid  output  1  port 0 read data valid (1-cycle pulse)
r0_rdata  output  W  port 0 read data
r1_valid, r1_we, r1_addr, r1_wdata, r1_ready, r1_rvalid, r1_rdata  same as port 0, for port 1
rf_write_en  output  1  to register file write_en
rf_addr  output  D  to register file addr
rf_data_in  output  W  to register file data_in
rf_data_out  input  W  from register file data_out (combinational read)
init_done  output  1  high once the init sweep has completed

Behaviour:
- State machine with two states, INIT and ARB. Registers: state, init_cnt[D-1:0], last_grant (1 bit), rvalid/rdata per port.
- Reset (sampled at posedge): state = INIT, init_cnt = 0, last_grant = 1, r*_rvalid = 0, r*_rdata = 0, init_done = 0.
- While reset is high, combinational outputs are forced: rf_write_en = 0, r*_ready = 0, rf_addr = 0, rf_data_in = 0.
- INIT state:
  - rf_write_en = 1, rf_addr = init_cnt, rf_data_in = 0; init_cnt increments each cycle.
  - r0_ready = r1_ready = 0; requests are held off, not dropped.
  - On the cycle with init_cnt = 2^D-1: next state = ARB, init_done goes 1 on the following edge.
  - The sweep lasts exactly 2^D cycles (16 at default). init_cnt wraps to 0, but that value is unused.
- ARB state, grant is combinational in the same cycle:
  - Only rX_valid high: grant X.
  - Both valid: grant the port that is not last_grant. At reset last_grant = 1, so port 0 wins the first tie.
  - Neither valid: no grant; rf_write_en = 0, rf_addr = 0, rf_data_in = 0.
- Granted port X drives the register file and its ready:
  - rX_ready = 1; the other port's ready = 0.
  - rf_addr = rX_addr, rf_write_en = rX_we, rf_data_in = rX_we ? rX_wdata : 0.
  - ready depends combinationally on valid; requesters must not make valid depend on ready.
- last_grant updates to X only on a grant; it holds otherwise.
- Read response:
  - On a read grant, rX_rdata <= rf_data_out and rX_rvalid <= 1 at the next edge, so latency is 1 cycle.
  - rvalid is a 1-cycle pulse. rX_rdata holds its value until the next read for that port.
  - Writes produce no response.
- Ordering: a write granted in cycle N is visible to a read granted in cycle N+1 or later, because the register file writes at posedge.
- Back-to-back: one port with continuous valid and no contention is granted every cycle. Under continuous contention grants alternate 0,1,0,1, so the maximum wait is 1 cycle.
- Reset mid-operation: any pending rvalid is cleared and its read data is dropped. The init sweep restarts from address 0, and init_done drops to 0 at the reset edge.
- init_done stays high in ARB until the next reset.

Test Plan:
- Reset, then idle 20 cycles -> rf_write_en = 1 with rf_addr = 0..15 in consecutive cycles and rf_data_in = 0; init_done = 1 from cycle 17; no ready asserted during the sweep; model register file then reads all zero.
- After init, port 0 writes addr 3 = 0xA5, then reads addr 3 the next cycle -> r0_ready on both cycles; r0_rvalid pulses one cycle after the read grant with r0_rdata = 0xA5.
- Both ports hold valid reads (addr 1 and addr 2) for 4 cycles -> grants go port 0, 1, 0, 1; each rvalid pulse carries the correct data; the non-granted ready is always 0.
- Port 1 requests continuously and port 0 requests only in cycle 2 -> port 1 is granted every cycle except cycle 2 if last_grant = 1 then; no cycle is left idle while a request is pending.
- Port 0 holds valid during the init sweep -> r0_ready = 0 for 16 cycles; the request is granted in the first ARB cycle.
- Assert reset the cycle after a read grant -> r0_rvalid stays 0; rf_addr restarts at 0 with rf_write_en = 1; init_done = 0.
